sm_uart_rx: RTL and testbench
=============================

Name: sm_uart_rx

Overview:
- UART 8N1 receiver with a 32-bit word assembler; upstream of sm_top on the board.
- Consumes the raw serial line from the USB-UART (UART_TXD_IN).
- Delivers received bytes and little-endian 32-bit words with one-cycle valid strobes.
- Intended consumer: instruction-memory program loader / debug register.

Parameters:
- BAUD_DIV, 868, clock cycles per bit (100 MHz / 115200); legal range 4..65535.
- TIMEOUT, 1000000, idle cycles after which a partial word is discarded; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rx  in  1  serial line, idle high, asynchronous to clk.
- byteData  out  8  last correctly framed byte.
- byteValid  out  1  one-cycle strobe; byteData is valid in the same cycle.
- frameErr  out  1  one-cycle strobe on a bad stop bit.
- wordData  out  32  assembled word; first received byte is in [7:0].
- wordValid  out  1  one-cycle strobe; wordData is valid in the same cycle.
- busy  out  1  high while the FSM is not IDLE.

Behaviour:
- Reset: all outputs 0; synchronizer flops preset to 1; FSM in IDLE; byte counter 0; all counters 0.
- Synchronizer: rx passes through 2 flops to give rxS, i.e. 2 cycles of latency. All decisions use rxS.
- Bit timer: down-counter cnt, 16 bits wide.
- IDLE: when rxS==0, go to START with cnt=BAUD_DIV/2-1 (integer division).
- START: decrement cnt. At cnt==0:
  - if rxS==0, go to DATA with cnt=BAUD_DIV-1 and bitIdx=0;
  - else the start bit was a glitch: return to IDLE with no strobe.
- DATA: at cnt==0, shift rxS into shift[7], shifting right (LSB first); bitIdx++ and reload cnt. After the sample with bitIdx==7, go to STOP with cnt=BAUD_DIV-1.
- STOP: at cnt==0:
  - if rxS==1: byteData<=shift, byteValid=1 for one cycle, go to IDLE;
  - else: frameErr=1 for one cycle, byteData unchanged, go to BREAK.
- BREAK: wait for rxS==1, then go to IDLE. This prevents a held-low line from being read as repeated start bits.
- Sampling: each bit is sampled at mid-bit. Byte strobe occurs about 9.5*BAUD_DIV+2 cycles after the start-bit falling edge on rx.
- Word assembler (sub-module): 2-bit byte counter bc.
  - On byteValid: acc[8*bc +: 8]<=byteData; bc++.
  - When bc==3 and byteValid: next cycle wordData<=completed acc, wordValid=1, bc<=0. wordValid therefore lags the 4th byteValid by exactly 1 cycle.
  - frameErr: bc<=0; partial word discarded; wordValid not asserted.
  - Timeout: idle counter increments while bc!=0 and there is no byteValid. It resets on byteValid. On reaching TIMEOUT, bc<=0. The counter saturates and never wraps.
  - byteValid and timeout expiry in the same cycle: byteValid wins, the byte is kept and the counter is cleared.
- rst_n asserted mid-frame: immediate return to reset state; no strobe is emitted for the partial frame.
- busy: combinational, FSM != IDLE.

Decomposition:
- Shared package: FSM state encoding (IDLE, START, DATA, STOP, BREAK as 3-bit localparams) and the default BAUD_DIV constant.
- One sub-module, sm_uart_word: byte-to-word assembler with timeout.
  - Inputs: byteData, byteValid, frameErr.
  - Outputs: wordData, wordValid.

Test Plan (BAUD_DIV=16, TIMEOUT=200):
- Send byte 0xA5 (8N1) -> exactly one byteValid with byteData=0xA5; frameErr stays 0; busy falls after the stop bit.
- Send 0x78,0x56,0x34,0x12 back-to-back -> 4 byteValid strobes, then wordValid one cycle after the 4th with wordData=0x12345678.
- Send 0x55 with stop bit driven 0, then release line high -> frameErr pulse, no byteValid, byteData keeps its previous value; then send 0x3C -> byteValid, byteData=0x3C.
- Pulse rx low for 4 cycles only -> no strobes; FSM back in IDLE before 16 cycles.
- Send 0x11,0x22, idle 250 cycles, then 0xDE,0xAD,0xBE,0xEF -> single wordValid with wordData=0xEFBEADDE; stale bytes discarded.
- Assert rst_n low during the DATA bits of 0xFF, release, send 0x81 -> no strobe from the aborted frame; byteData=0x81 received correctly.

Source files
------------

// File: rtl/sm_uart_rx_pkg.sv
// sm_uart_rx_pkg: shared definitions for the UART 8N1 receiver.
// Contents: receiver FSM state encoding (3-bit), default bit period and
// default word-assembly idle timeout.
package sm_uart_rx_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP,
    BREAK = ST_BREAK
  } rx_state_e;

  // 100 MHz / 115200 baud
  localparam int DEFAULT_BAUD_DIV = 868;
  localparam int DEFAULT_TIMEOUT  = 1000000;

endpackage

// File: rtl/sm_uart_rx_if.sv
// sm_uart_rx_if: serial line plus received byte/word strobes.
//   rx        serial line into the receiver (idle high)
//   byteData  last correctly framed byte, byteValid one-cycle strobe
//   frameErr  one-cycle strobe on a bad stop bit
//   wordData  little-endian assembled word, wordValid one-cycle strobe
//   busy      receiver FSM not idle
// master = receiver side, slave = line driver / consumer side.
interface sm_uart_rx_if;
  logic        rx;
  logic [7:0]  byteData;
  logic        byteValid;
  logic        frameErr;
  logic [31:0] wordData;
  logic        wordValid;
  logic        busy;

  modport master (
    input  rx,
    output byteData, byteValid, frameErr, wordData, wordValid, busy
  );

  modport slave (
    output rx,
    input  byteData, byteValid, frameErr, wordData, wordValid, busy
  );
endinterface

// File: rtl/sm_uart_word.sv
// sm_uart_word: packs received bytes into little-endian 32-bit words.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   byteData/byteValid  received byte and its one-cycle strobe
//   frameErr            framing error strobe, drops any partial word
//   wordData/wordValid  completed word, strobe one cycle after 4th byte
// A partial word is discarded once TIMEOUT cycles pass without a byte
// (TIMEOUT = 0 disables this).
module sm_uart_word
  import sm_uart_rx_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byteData,
  input  logic        byteValid,
  input  logic        frameErr,
  output logic [31:0] wordData,
  output logic        wordValid
);

  localparam int            IW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] TO_VAL = IW'(TIMEOUT);

  logic [1:0]    r_bc;
  logic [31:0]   r_acc;
  logic [IW-1:0] r_idle;
  logic [31:0]   r_word_data;
  logic          r_word_valid;
  logic          w_expire;

  // Idle counter saturates at TO_VAL, so equality marks expiry while a word is open.
  assign w_expire = (TIMEOUT != 32'sd0) && (r_bc != 2'd0) && (r_idle == TO_VAL);

  // Byte placement, word completion and stale-word discard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bc         <= 2'd0;
      r_acc        <= 32'd0;
      r_idle       <= '0;
      r_word_data  <= 32'd0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      // byteValid is checked first so it wins over a simultaneous expiry.
      if (byteValid) begin
        r_acc[{r_bc, 3'b000} +: 8] <= byteData;
        r_idle                     <= '0;
        if (r_bc == 2'd3) begin
          r_word_data  <= {byteData, r_acc[23:0]};
          r_word_valid <= 1'b1;
          r_bc         <= 2'd0;
        end else begin
          r_bc <= r_bc + 2'd1;
        end
      end else if (frameErr) begin
        r_bc   <= 2'd0;
        r_idle <= '0;
      end else if (w_expire) begin
        r_bc <= 2'd0;
      end else if (r_bc == 2'd0) begin
        r_idle <= '0;
      end else if (r_idle != TO_VAL) begin
        r_idle <= r_idle + IW'(1);
      end else begin
        r_idle <= r_idle;
      end
    end
  end

  assign wordData  = r_word_data;
  assign wordValid = r_word_valid;

endmodule

// File: rtl/sm_uart_rx.sv
// sm_uart_rx: UART 8N1 receiver with 32-bit word assembler.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    sm_uart_rx_if.master: rx in; byte/word/frame strobes and busy out
// Bits are sampled at mid-bit from a 2-flop synchronised copy of rx.
module sm_uart_rx
  import sm_uart_rx_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
  parameter int TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  sm_uart_rx_if.master  bus
);

  localparam logic [15:0] HALF_RELOAD = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL_RELOAD = 16'(BAUD_DIV - 1);

  logic [1:0]  r_sync;
  logic        w_rxs;
  rx_state_e   r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_bit_idx, w_bit_idx_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        w_byte_ok, w_frame_bad;
  logic [7:0]  r_byte_data;
  logic        r_byte_valid;
  logic        r_frame_err;
  logic [31:0] w_word_data;
  logic        w_word_valid;

  assign w_rxs = r_sync[1];

  // Two-flop synchroniser; preset high so reset looks like an idle line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], bus.rx};
    end
  end

  // Next-state, bit-timer and shift-register logic of the receiver FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_byte_ok     = 1'b0;
    w_frame_bad   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rxs) begin
          w_state_nxt = START;
          w_cnt_nxt   = HALF_RELOAD;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (r_cnt != 16'd0) begin
          w_cnt_nxt = r_cnt - 16'd1;
        end else if (!w_rxs) begin
          w_state_nxt   = DATA;
          w_cnt_nxt     = FULL_RELOAD;
          w_bit_idx_nxt = 3'd0;
        end else begin
          // Line went high again before mid start bit: treat as a glitch.
          w_state_nxt = IDLE;
        end
      end
      DATA: begin
        if (r_cnt != 16'd0) begin
          w_cnt_nxt = r_cnt - 16'd1;
        end else begin
          w_shift_nxt   = {w_rxs, r_shift[7:1]};
          w_cnt_nxt     = FULL_RELOAD;
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_state_nxt = DATA;
          end
        end
      end
      STOP: begin
        if (r_cnt != 16'd0) begin
          w_cnt_nxt = r_cnt - 16'd1;
        end else if (w_rxs) begin
          w_byte_ok   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_frame_bad = 1'b1;
          w_state_nxt = BREAK;
        end
      end
      BREAK: begin
        // Hold here until the line is released so a stuck-low line is not re-read as start bits.
        if (w_rxs) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = BREAK;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state, timers and registered byte/frame-error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= 16'd0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'd0;
      r_byte_data  <= 8'd0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_byte_valid <= w_byte_ok;
      r_frame_err  <= w_frame_bad;
      if (w_byte_ok) begin
        r_byte_data <= r_shift;
      end else begin
        r_byte_data <= r_byte_data;
      end
    end
  end

  sm_uart_word #(
    .TIMEOUT (TIMEOUT)
  ) u_word (
    .clk       (clk),
    .rst_n     (rst_n),
    .byteData  (r_byte_data),
    .byteValid (r_byte_valid),
    .frameErr  (r_frame_err),
    .wordData  (w_word_data),
    .wordValid (w_word_valid)
  );

  assign bus.byteData  = r_byte_data;
  assign bus.byteValid = r_byte_valid;
  assign bus.frameErr  = r_frame_err;
  assign bus.wordData  = w_word_data;
  assign bus.wordValid = w_word_valid;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_sm_uart_rx.sv
// Scoreboard bench for sm_uart_rx: the stimulus side pushes expected bytes,
// framing errors and words (with expected strobe cycles) into queues; a
// negedge monitor pops and compares whenever the DUT strobes.
module tb_sm_uart_rx;

  localparam int BD = 16;
  localparam int TO = 200;
  // Cycles from driving the start-bit edge to seeing the byte strobe:
  // 2 sync flops + half bit + 9 full bits + 1 output register.
  localparam int LAT = 3 + BD / 2 + 9 * BD;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  exp_t        q_byte[$];
  exp_t        q_word[$];
  exp_t        q_ferr[$];
  logic [7:0]  part[$];
  int          last_strobe = 0;
  logic [7:0]  last_good = 8'h00;

  sm_uart_rx_if bus ();

  sm_uart_rx #(
    .BAUD_DIV (BD),
    .TIMEOUT  (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_near(input string name, input int act, input int exp, input int tol);
    n_chk++;
    if (act >= exp - tol && act <= exp + tol) n_pass++;
    else $display("FAIL %s: got cycle %0d, expected cycle %0d +/- %0d", name, act, exp, tol);
  endtask

  // Reference model: record what one frame should produce, then drive it.
  task automatic send(input logic [7:0] b, input logic stop_bit);
    int t;
    t = cyc + LAT;
    if (stop_bit) begin
      if (part.size() != 0 && (t - last_strobe) > TO) part.delete();
      q_byte.push_back('{data: {24'h0, b}, cyc: t});
      part.push_back(b);
      last_strobe = t;
      last_good = b;
      if (part.size() == 4) begin
        q_word.push_back('{data: {part[3], part[2], part[1], part[0]}, cyc: t + 1});
        part.delete();
      end
    end else begin
      q_ferr.push_back('{data: {24'h0, last_good}, cyc: t});
      part.delete();
    end
    bus.rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (BD) @(negedge clk);
    end
    bus.rx = stop_bit;
    repeat (BD) @(negedge clk);
    bus.rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare every DUT strobe against the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.byteValid) begin
        if (q_byte.size() == 0) chk("spurious byteValid", {31'd0, bus.byteValid}, 32'd0);
        else begin
          e = q_byte.pop_front();
          chk("byteData", {24'h0, bus.byteData}, e.data);
          chk_near("byteValid timing", cyc, e.cyc, 1);
        end
      end
      if (bus.frameErr) begin
        if (q_ferr.size() == 0) chk("spurious frameErr", {31'd0, bus.frameErr}, 32'd0);
        else begin
          e = q_ferr.pop_front();
          chk("byteData held on frameErr", {24'h0, bus.byteData}, e.data);
          chk_near("frameErr timing", cyc, e.cyc, 1);
        end
      end
      if (bus.wordValid) begin
        if (q_word.size() == 0) chk("spurious wordValid", {31'd0, bus.wordValid}, 32'd0);
        else begin
          e = q_word.pop_front();
          chk("wordData", bus.wordData, e.data);
          chk_near("wordValid timing", cyc, e.cyc, 0);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [7:0] rb;
    logic       rs;
    bus.rx = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset byteData", {24'h0, bus.byteData}, 32'h0);
    chk("reset byteValid", {31'd0, bus.byteValid}, 32'h0);
    chk("reset frameErr", {31'd0, bus.frameErr}, 32'h0);
    chk("reset wordData", bus.wordData, 32'h0);
    chk("reset wordValid", {31'd0, bus.wordValid}, 32'h0);
    chk("reset busy", {31'd0, bus.busy}, 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Single byte; busy must be low once the stop bit is over.
    send(8'hA5, 1'b1);
    chk("busy after stop", {31'd0, bus.busy}, 32'h0);
    idle(250);

    // Four back-to-back bytes -> one word.
    send(8'h78, 1'b1);
    send(8'h56, 1'b1);
    send(8'h34, 1'b1);
    send(8'h12, 1'b1);
    idle(4);

    // Bad stop bit, then a good byte.
    send(8'h55, 1'b0);
    idle(BD);
    send(8'h3C, 1'b1);
    idle(4);

    // Short low glitch: no strobe, FSM idle again within 16 cycles.
    bus.rx = 1'b0;
    idle(4);
    bus.rx = 1'b1;
    chk("busy during glitch", {31'd0, bus.busy}, 32'h1);
    idle(12);
    chk("busy after glitch", {31'd0, bus.busy}, 32'h0);
    idle(4);

    // Stale partial word discarded by the idle timeout.
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    idle(250);
    send(8'hDE, 1'b1);
    send(8'hAD, 1'b1);
    send(8'hBE, 1'b1);
    send(8'hEF, 1'b1);
    idle(4);

    // Reset in the middle of the data bits of 0xFF.
    bus.rx = 1'b0;
    idle(BD);
    bus.rx = 1'b1;
    idle(3 * BD);
    rst_n = 1'b0;
    part.delete();
    last_good = 8'h00;
    @(negedge clk);
    chk("mid-frame reset byteData", {24'h0, bus.byteData}, 32'h0);
    chk("mid-frame reset wordData", bus.wordData, 32'h0);
    chk("mid-frame reset busy", {31'd0, bus.busy}, 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(2 * BD);
    send(8'h81, 1'b1);
    idle(4);

    // Random bytes with occasional framing errors and short gaps.
    for (int k = 0; k < 16; k++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 5) != 0);
      send(rb, rs);
      if (rs) idle($urandom_range(0, 30));
      else idle(BD + $urandom_range(0, 10));
    end

    w = 0;
    while ((q_byte.size() + q_word.size() + q_ferr.size()) != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("byte queue drained", 32'(q_byte.size()), 32'h0);
    chk("word queue drained", 32'(q_word.size()), 32'h0);
    chk("frameErr queue drained", 32'(q_ferr.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
